// File: rtl/alu_dispatch.sv
`default_nettype none
// ============================================================================
//  Module   : alu_dispatch
//  Purpose  : Request buffer and issue pipeline in front of a combinational
//             ALU. Tagged requests are queued in a DEPTH-entry FIFO, issued
//             one per cycle into a register stage that drives the ALU inputs,
//             and the ALU result is captured with its tag into a response
//             register that honours valid/ready backpressure.
//  Ports    : clk, rst               - clock, synchronous active-high reset
//             req_valid/req_ready    - request handshake
//             req_op/lhs/rhs/tag     - request payload
//             alu_operation/lhs/rhs  - registered ALU inputs
//             alu_result             - combinational ALU result
//             rsp_valid/rsp_ready    - response handshake
//             rsp_result/rsp_tag     - response payload
//             count                  - FIFO occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module alu_dispatch #(
    parameter int OPERAND_WIDTH = 32,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [4:0]                   req_op,
    input  logic [OPERAND_WIDTH:0]       req_lhs,
    input  logic [OPERAND_WIDTH:0]       req_rhs,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    output logic [4:0]                   alu_operation,
    output logic [OPERAND_WIDTH:0]       alu_lhs,
    output logic [OPERAND_WIDTH:0]       alu_rhs,
    input  logic [OPERAND_WIDTH:0]       alu_result,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [OPERAND_WIDTH:0]       rsp_result,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_W     = OPERAND_WIDTH + 1;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = $clog2(DEPTH + 1);
    localparam int c_ENTRY = 5 + 2 * c_W + TAG_WIDTH;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [c_ENTRY-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;

    // Issue stage
    logic                 r_iss_valid;
    logic [4:0]           r_iss_op;
    logic [c_W-1:0]       r_iss_lhs;
    logic [c_W-1:0]       r_iss_rhs;
    logic [TAG_WIDTH-1:0] r_iss_tag;

    // Response stage
    logic                 r_rsp_valid;
    logic [c_W-1:0]       r_rsp_result;
    logic [TAG_WIDTH-1:0] r_rsp_tag;

    // Control
    logic                 w_push;
    logic                 w_load;
    logic                 w_rsp_free;
    logic                 w_advance;
    logic                 w_fifo_empty;
    logic [c_ENTRY-1:0]   w_wr_entry;
    logic [c_ENTRY-1:0]   w_head;
    logic [4:0]           w_head_op;
    logic [c_W-1:0]       w_head_lhs;
    logic [c_W-1:0]       w_head_rhs;
    logic [TAG_WIDTH-1:0] w_head_tag;

    // req_ready is a function of the registered count only, so there is no
    // combinational path from rsp_ready back to req_ready.
    assign req_ready    = (r_count != c_CW'(DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = req_valid && req_ready;

    assign w_rsp_free   = !r_rsp_valid || rsp_ready;
    assign w_advance    = r_iss_valid && w_rsp_free;
    // The issue register refills from the FIFO head when it is empty or is
    // handing its content to the response stage on this same edge.
    assign w_load       = !w_fifo_empty && (!r_iss_valid || w_advance);

    assign w_wr_entry   = {req_op, req_lhs, req_rhs, req_tag};
    assign w_head       = r_mem[r_rd_ptr];
    assign {w_head_op, w_head_lhs, w_head_rhs, w_head_tag} = w_head;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: pointers/count qualify the contents)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy; DEPTH is a power of two so the pointers
    // wrap naturally.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue stage: holds ALU inputs stable unless a new entry is loaded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_op    <= '0;
            r_iss_lhs   <= '0;
            r_iss_rhs   <= '0;
            r_iss_tag   <= '0;
        end else if (w_load) begin
            r_iss_valid <= 1'b1;
            r_iss_op    <= w_head_op;
            r_iss_lhs   <= w_head_lhs;
            r_iss_rhs   <= w_head_rhs;
            r_iss_tag   <= w_head_tag;
        end else if (w_advance) begin
            r_iss_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Response stage: captures the combinational ALU result together with
    // the tag of the operation that produced it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
        end else if (w_advance) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= alu_result;
            r_rsp_tag    <= r_iss_tag;
        end else if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
        end
    end

    assign alu_operation = r_iss_op;
    assign alu_lhs       = r_iss_lhs;
    assign alu_rhs       = r_iss_rhs;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_tag       = r_rsp_tag;
    assign count         = r_count;

endmodule
`default_nettype wire
